// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// audio_i2s_tx : I2S transmitter with a stereo-sample FIFO. BCLK and LRCLK are
//                derived from the audio master clock.
// Revision 1.0
// ============================================================================
module audio_i2s_tx #(
   parameter int DATA_W     = 24,
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        pll_locked,
   input  logic                        enable,
   input  logic [DATA_W-1:0]           in_left,
   input  logic [DATA_W-1:0]           in_right,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        i2s_bclk,
   output logic                        i2s_lrclk,
   output logic                        i2s_sdata,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underrun,
   input  logic                        underrun_clr,
   output logic                        busy
);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = ADDR_W + 1;
   localparam int DIV_W  = $clog2(BCLK_DIV);
   localparam int PAD    = 31 - DATA_W;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DIV_W-1:0]    div_cnt;
   logic [DIV_W-1:0]    div_next;
   logic [5:0]          bit_cnt;
   logic [5:0]          bit_next;
   logic [DATA_W-1:0]   frame_left;
   logic [DATA_W-1:0]   frame_right;
   logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]    level;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                pop_ok;
   logic                counting;
   logic                div_wrap;
   logic                frame_wrap;
   logic [DATA_W-1:0]   slot_chan;
   logic [31:0]         slot_word;
   logic [4:0]          slot_idx;
   logic                sdata_next;

   assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   assign in_ready   = !fifo_full && pll_locked;
   assign push       = in_valid && in_ready;
   assign pop_ok     = pop && !fifo_empty;
   assign div_wrap   = (div_cnt == DIV_LAST);
   assign frame_wrap = div_wrap && (bit_cnt == 6'd63);
   assign fifo_level = level;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      counting   = 1'b0;
      if (!pll_locked) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state_next = RUN;
                  pop        = 1'b1;
               end
            end
            RUN: begin
               counting = 1'b1;
               pop      = frame_wrap;
               if (!enable) begin
                  state_next = DRAIN;
               end
            end
            DRAIN: begin
               counting = 1'b1;
               // Re-enabling while draining resumes without breaking the frame.
               if (enable) begin
                  state_next = RUN;
                  pop        = frame_wrap;
               end else if (frame_wrap) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      div_next = div_cnt;
      bit_next = bit_cnt;
      if (counting) begin
         if (div_wrap) begin
            div_next = '0;
            bit_next = bit_cnt + 6'd1;
         end else begin
            div_next = div_cnt + DIV_W'(1);
         end
      end
   end

   // Slot word holds a leading 0 (the one-BCLK I2S delay), the sample MSB-first, then zero padding.
   always_comb begin
      slot_chan  = bit_next[5] ? frame_right : frame_left;
      slot_word  = 32'({1'b0, slot_chan}) << PAD;
      slot_idx   = 5'd31 - bit_next[4:0];
      sdata_next = slot_word[slot_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
      end else if (state_next == IDLE) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
      end else begin
         div_cnt   <= div_next;
         bit_cnt   <= bit_next;
         i2s_bclk  <= (div_next >= DIV_HALF);
         i2s_lrclk <= bit_next[5];
         i2s_sdata <= sdata_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_left, in_right};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (!pll_locked) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         level <= level + LVL_W'(push) - LVL_W'(pop_ok);
      end
   end

   // An empty FIFO at a frame start transmits silence rather than stale data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_left  <= '0;
         frame_right <= '0;
      end else if (pop) begin
         if (fifo_empty) begin
            frame_left  <= '0;
            frame_right <= '0;
         end else begin
            frame_left  <= mem[rd_ptr][2*DATA_W-1:DATA_W];
            frame_right <= mem[rd_ptr][DATA_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         underrun <= 1'b0;
      end else if (pop && fifo_empty) begin
         underrun <= 1'b1;
      end else if (underrun_clr) begin
         underrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_audio_i2s_tx : directed bench for audio_i2s_tx at default parameters.
// Revision 1.0
// ============================================================================
module tb_audio_i2s_tx;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        pll_locked;
   logic        enable;
   logic [23:0] in_left;
   logic [23:0] in_right;
   logic        in_valid;
   logic        in_ready;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic [2:0]  fifo_level;
   logic        underrun;
   logic        underrun_clr;
   logic        busy;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic [23:0] l;
      logic [23:0] r;
      logic [63:0] stream;
   } vec_t;

   vec_t vecs[5];

   localparam logic [63:0] LR_PATTERN = 64'h00000000_FFFFFFFF;

   logic [63:0] frames[$];
   logic [63:0] lrs[$];
   longint      starts[$];
   int          mon_bit = 0;
   logic [63:0] mon_stream;
   logic [63:0] mon_lr;

   audio_i2s_tx dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .enable       (enable),
      .in_left      (in_left),
      .in_right     (in_right),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .fifo_level   (fifo_level),
      .underrun     (underrun),
      .underrun_clr (underrun_clr),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Frame capture: data is stable at every BCLK rising edge; a partial frame is dropped when busy falls.
   always @(posedge i2s_bclk or negedge busy) begin
      if (busy !== 1'b1) begin
         mon_bit = 0;
      end else begin
         if (mon_bit == 0) begin
            starts.push_back($time);
         end
         mon_stream = {mon_stream[62:0], i2s_sdata};
         mon_lr     = {mon_lr[62:0], i2s_lrclk};
         mon_bit++;
         if (mon_bit == 64) begin
            frames.push_back(mon_stream);
            lrs.push_back(mon_lr);
            mon_bit = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (frames.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("frame_count", 64'(frames.size()), 64'(n));
   endtask

   function automatic logic [63:0] frame_at(input int i);
      return (i < frames.size()) ? frames[i] : 64'hx;
   endfunction

   function automatic logic [63:0] lr_at(input int i);
      return (i < lrs.size()) ? lrs[i] : 64'hx;
   endfunction

   function automatic logic [63:0] period_at(input int i);
      return (i + 1 < starts.size()) ? 64'(starts[i+1] - starts[i]) : 64'hx;
   endfunction

   task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
      in_left  = l;
      in_right = r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int  cnt;
      bit  saw_bclk;
      bit  saw_busy;

      // Expected streams: each slot = {0, sample[23:0], 7'b0}, left slot first.
      vecs[0] = '{24'h800001, 24'h7FFFFF, 64'h40000080_3FFFFF80};
      vecs[1] = '{24'h000000, 24'hFFFFFF, 64'h00000000_7FFFFF80};
      vecs[2] = '{24'hA5A5A5, 24'h123456, 64'h52D2D280_091A2B00};
      vecs[3] = '{24'hFFFFFF, 24'h000001, 64'h7FFFFF80_00000080};
      vecs[4] = '{24'h400000, 24'hC00000, 64'h20000000_60000000};

      reset_n      = 1'b0;
      pll_locked   = 1'b0;
      enable       = 1'b0;
      in_left      = '0;
      in_right     = '0;
      in_valid     = 1'b0;
      underrun_clr = 1'b0;
      ticks(3);
      check("reset_outputs", 64'({in_ready, i2s_bclk, i2s_lrclk, i2s_sdata, fifo_level, underrun, busy}), 64'd0);
      reset_n = 1'b1;
      tick();

      // PLL unlocked: enable must not start anything.
      enable   = 1'b1;
      saw_bclk = 1'b0;
      saw_busy = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (i2s_bclk !== 1'b0) saw_bclk = 1'b1;
         if (busy !== 1'b0) saw_busy = 1'b1;
      end
      check("unlocked_bclk", 64'(saw_bclk), 64'd0);
      check("unlocked_busy", 64'(saw_busy), 64'd0);
      check("unlocked_in_ready", 64'(in_ready), 64'd0);
      enable = 1'b0;

      // Entry with an empty FIFO while a push arrives in the same cycle.
      pll_locked = 1'b1;
      tick();
      check("locked_in_ready", 64'(in_ready), 64'd1);
      frames.delete(); lrs.delete(); starts.delete();
      enable   = 1'b1;
      in_left  = vecs[0].l;
      in_right = vecs[0].r;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("entry_busy", 64'(busy), 64'd1);
      check("entry_underrun", 64'(underrun), 64'd1);
      check("entry_push_kept", 64'(fifo_level), 64'd1);
      cnt = 0;
      while (i2s_bclk !== 1'b1 && cnt < 10) begin
         tick();
         cnt++;
      end
      check("first_bclk_rise", 64'(cnt), 64'd2);
      enable = 1'b0;
      wait_frames(1, 400);
      check("underrun_frame", frame_at(0), 64'd0);
      check("underrun_lrclk", lr_at(0), LR_PATTERN);
      check("drain_busy", 64'(busy), 64'd1);
      ticks(2);
      check("drain_idle", 64'(busy), 64'd0);
      check("drain_no_pop", 64'(fifo_level), 64'd1);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("underrun_clr", 64'(underrun), 64'd0);

      // Fill to full while idle; the fifth pair waits for the first pop.
      for (int i = 1; i < 4; i++) push_pair(vecs[i].l, vecs[i].r);
      in_left  = vecs[4].l;
      in_right = vecs[4].r;
      in_valid = 1'b1;
      ticks(5);
      check("full_level", 64'(fifo_level), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      frames.delete(); lrs.delete(); starts.delete();
      enable = 1'b1;
      tick();
      check("first_pop_level", 64'(fifo_level), 64'd3);
      check("first_pop_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("held_push_level", 64'(fifo_level), 64'd4);

      wait_frames(5, 5 * 256 + 100);
      check("no_underrun_yet", 64'(underrun), 64'd0);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("frame%0d_data", i), frame_at(i), vecs[i].stream);
         check($sformatf("frame%0d_lrclk", i), lr_at(i), LR_PATTERN);
         if (i < 4) check($sformatf("frame%0d_period", i), period_at(i), 64'd2560);
      end

      wait_frames(6, 300);
      check("empty_frame", frame_at(5), 64'd0);
      check("empty_underrun", 64'(underrun), 64'd1);
      ticks(10);
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("clr_mid_frame", 64'(underrun), 64'd0);
      wait_frames(7, 300);
      check("clr_holds", 64'(underrun), 64'd0);
      // Clear pulse lands on the next empty frame start: the set wins.
      tick();
      underrun_clr = 1'b1;
      tick();
      underrun_clr = 1'b0;
      check("set_beats_clr", 64'(underrun), 64'd1);

      // Stop mid-frame at bit_cnt 10.
      push_pair(24'h000001, 24'h800000);
      push_pair(24'h123456, 24'h654321);
      check("two_queued", 64'(fifo_level), 64'd2);
      wait_frames(8, 300);
      ticks(2);
      ticks(40);
      enable = 1'b0;
      check("stop_level", 64'(fifo_level), 64'd1);
      wait_frames(9, 300);
      check("stop_frame", frame_at(8), 64'h00000080_40000000);
      check("stop_still_busy", 64'(busy), 64'd1);
      ticks(2);
      check("stop_idle", 64'({busy, i2s_bclk}), 64'd0);
      check("stop_no_extra_pop", 64'(fifo_level), 64'd1);
      ticks(300);
      check("stop_stays_idle", 64'({busy, fifo_level}), 64'd1);

      // Lock loss mid-frame with three entries queued.
      for (int i = 1; i < 4; i++) push_pair(vecs[i].l, vecs[i].r);
      enable = 1'b1;
      tick();
      cnt = 0;
      while (!(i2s_bclk === 1'b1 && i2s_lrclk === 1'b1) && cnt < 400) begin
         tick();
         cnt++;
      end
      check("right_slot_reached", 64'({i2s_bclk, i2s_lrclk}), 64'b11);
      check("lock_loss_level_before", 64'(fifo_level), 64'd3);
      pll_locked = 1'b0;
      tick();
      check("lock_loss_lines", 64'({i2s_bclk, i2s_lrclk, i2s_sdata}), 64'd0);
      check("lock_loss_flush", 64'(fifo_level), 64'd0);
      check("lock_loss_busy", 64'(busy), 64'd0);
      check("lock_loss_underrun_kept", 64'(underrun), 64'd1);
      check("lock_loss_in_ready", 64'(in_ready), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
